// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, width and fetch-action definitions for the CPU front end
package cpu_pkg;

  localparam int INSTR_W = 16;
  localparam int PC_W    = 16;

  typedef enum logic [3:0] {
    OP_TYPEA = 4'b0000,
    OP_BLT   = 4'b0100,
    OP_BGT   = 4'b0101,
    OP_BEQ   = 4'b0110,
    OP_LW    = 4'b1000,
    OP_SW    = 4'b1011,
    OP_JMP   = 4'b1100,
    OP_NOP   = 4'b1110,
    OP_HALT  = 4'b1111
  } opcode_e;

  // What the fetch stage does on the coming edge, already resolved by priority.
  typedef enum logic [2:0] {
    ACT_REDIRECT,
    ACT_HALTED,
    ACT_STALL,
    ACT_FETCH,
    ACT_HALT_FETCH
  } fetch_act_e;

  function automatic fetch_act_e resolve_action(
    input logic redirect,
    input logic halted,
    input logic stall,
    input logic fetched_halt
  );
    if (redirect)          return ACT_REDIRECT;
    else if (halted)       return ACT_HALTED;
    else if (stall)        return ACT_STALL;
    else if (fetched_halt) return ACT_HALT_FETCH;
    else                   return ACT_FETCH;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with flush, bubble and hold control
module if_id_reg #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               bubble_i,
  input  logic               load_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o,
  output logic               valid_o
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic               valid_q, valid_d;

  // Flush wipes the word; a bubble only drops valid. Neither asserted and no load means hold.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (flush_i) begin
      instr_d = '0;
      valid_d = 1'b0;
    end else if (bubble_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d = instr_i;
      pc_d    = pc_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_o = instr_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, next-PC selection and IF/ID handoff to the decoder
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int               INSTR_W     = cpu_pkg::INSTR_W,
  parameter int               PC_W        = cpu_pkg::PC_W,
  parameter int               PC_STEP     = 2,
  parameter logic [PC_W-1:0]  RESET_PC    = '0,
  parameter logic [3:0]       NOP_OPCODE  = OP_NOP,
  parameter logic [3:0]       HALT_OPCODE = OP_HALT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic               ifid_valid,
  output logic [3:0]         ifid_opcode,
  output logic               halted
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            halted_q, halted_d;
  logic [PC_W-1:0] pc_inc;
  logic            fetched_halt;
  fetch_act_e      act;

  // Wraps modulo 2^PC_W by construction.
  assign pc_inc       = pc_q + PC_W'(PC_STEP);
  assign fetched_halt = (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);
  assign act          = resolve_action(redirect, halted_q, stall, fetched_halt);

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    case (act)
      ACT_REDIRECT: begin
        pc_d     = redirect_pc;
        halted_d = 1'b0;
      end
      ACT_HALT_FETCH: halted_d = 1'b1;
      ACT_FETCH:      pc_d     = pc_inc;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  if_id_reg #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (act == ACT_REDIRECT),
    .bubble_i (act == ACT_HALTED),
    .load_i   ((act == ACT_FETCH) || (act == ACT_HALT_FETCH)),
    .instr_i  (imem_rdata),
    .pc_i     (pc_inc),
    .instr_o  (ifid_instr),
    .pc_o     (ifid_pc),
    .valid_o  (ifid_valid)
  );

  assign imem_addr   = pc_q;
  assign halted      = halted_q;
  // Bubbles must never look like opcode 0000, which writes a register.
  assign ifid_opcode = ifid_valid ? ifid_instr[INSTR_W-1 -: 4] : NOP_OPCODE;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc;
  logic        ifid_valid;
  logic [3:0]  ifid_opcode;
  logic        halted;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ipc;
    logic        v;
    logic        h;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_valid  (ifid_valid),
    .ifid_opcode (ifid_opcode),
    .halted      (halted)
  );

  function automatic logic [15:0] mem_read(input logic [15:0] addr);
    case (addr)
      16'h0000: return 16'h0123;
      16'h0002: return 16'h8456;
      16'h0004: return 16'hB789;
      16'h0010: return 16'hF000;
      16'h0052: return 16'hF0AA;
      default:  return {4'h2, addr[11:0]};
    endcase
  endfunction

  assign imem_rdata = mem_read(imem_addr);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic step(input logic rn, input logic st, input logic rd, input logic [15:0] rpc);
    exp_t e;
    logic [15:0] r;
    @(negedge clk);
    rst_n = rn; stall = st; redirect = rd; redirect_pc = rpc;
    if (!rn) begin
      m.pc = 16'h0000; m.instr = '0; m.ipc = '0; m.v = 1'b0; m.h = 1'b0;
    end else if (rd) begin
      m.pc = rpc; m.v = 1'b0; m.instr = '0; m.h = 1'b0;
    end else if (m.h) begin
      m.v = 1'b0;
    end else if (!st) begin
      r = mem_read(m.pc);
      m.instr = r; m.ipc = m.pc + 16'd2; m.v = 1'b1;
      if (r[15:12] == 4'hF) m.h = 1'b1;
      else m.pc = m.pc + 16'd2;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("sb_addr",  32'(imem_addr),  32'(e.pc));
      chk("sb_instr", 32'(ifid_instr), 32'(e.instr));
      chk("sb_ipc",   32'(ifid_pc),    32'(e.ipc));
      chk("sb_valid", 32'(ifid_valid), 32'(e.v));
      chk("sb_op",    32'(ifid_opcode), 32'(e.v ? e.instr[15:12] : 4'hE));
      chk("sb_halt",  32'(halted),     32'(e.h));
    end
  endtask

  initial begin
    logic [15:0] tgt [6];
    tgt = '{16'h0000, 16'h0010, 16'h0040, 16'h0050, 16'hFFFC, 16'h0020};
    m = '{16'h0, 16'h0, 16'h0, 1'b0, 1'b0};

    step(1'b0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b0, 16'h0);
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'h0);
    chk("rst_op", 32'(ifid_opcode), 32'hE);
    chk("rst_halt", 32'(halted), 32'h0);

    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t1_instr0", 32'(ifid_instr), 32'h0123);
    chk("t1_pc0", 32'(ifid_pc), 32'h2);
    chk("t1_op0", 32'(ifid_opcode), 32'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t1_op1", 32'(ifid_opcode), 32'h8);
    chk("t1_pc1", 32'(ifid_pc), 32'h4);

    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t2_addr_hold", 32'(imem_addr), 32'h4);
    chk("t2_instr_hold", 32'(ifid_instr), 32'h8456);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t2_op2", 32'(ifid_opcode), 32'hB);
    chk("t2_pc2", 32'(ifid_pc), 32'h6);
    chk("t2_resume", 32'(imem_addr), 32'h6);

    step(1'b1, 1'b1, 1'b1, 16'h0040);
    chk("t3_addr", 32'(imem_addr), 32'h40);
    chk("t3_valid", 32'(ifid_valid), 32'h0);
    chk("t3_op", 32'(ifid_opcode), 32'hE);
    step(1'b1, 1'b0, 1'b0, 16'h0);

    step(1'b1, 1'b0, 1'b1, 16'h0010);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t4_op", 32'(ifid_opcode), 32'hF);
    chk("t4_valid", 32'(ifid_valid), 32'h1);
    chk("t4_halt", 32'(halted), 32'h1);
    chk("t4_addr", 32'(imem_addr), 32'h10);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t4_bubble", 32'(ifid_valid), 32'h0);
    chk("t4_frozen", 32'(imem_addr), 32'h10);

    step(1'b1, 1'b0, 1'b1, 16'h0020);
    chk("t5_unhalt", 32'(halted), 32'h0);
    chk("t5_addr0", 32'(imem_addr), 32'h20);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t5_addr1", 32'(imem_addr), 32'h22);

    step(1'b1, 1'b0, 1'b1, 16'h0010);
    step(1'b1, 1'b0, 1'b1, 16'h0030);
    chk("halt_vs_redirect", 32'(halted), 32'h0);
    chk("halt_vs_redirect_addr", 32'(imem_addr), 32'h30);

    step(1'b1, 1'b0, 1'b1, 16'hFFFE);
    step(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t6_wrap", 32'(imem_addr), 32'h0);
    chk("t6_wrap_ipc", 32'(ifid_pc), 32'h0);
    step(1'b1, 1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 1'b0, 16'h0);
    chk("t6_rst_addr", 32'(imem_addr), 32'h0);
    chk("t6_rst_instr", 32'(ifid_instr), 32'h0);
    chk("t6_rst_valid", 32'(ifid_valid), 32'h0);
    chk("t6_rst_halt", 32'(halted), 32'h0);

    for (int i = 0; i < 300; i++) begin
      step(($urandom % 40) != 0, ($urandom % 4) == 0, ($urandom % 6) == 0,
           tgt[$urandom_range(0, 5)]);
    end

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
